unified_mem_arbiter: RTL



---
 rtl/unified_mem_arbiter_pkg.sv | 15 +
 rtl/mem_watchdog.sv | 39 +++
 rtl/unified_mem_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter and the cache controller that will follow it.
// The state encoding is fixed so other blocks can decode it directly.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_e;

    localparam int DEFAULT_AW = 32;
    localparam int DEFAULT_DW = 32;
    localparam int WDOG_W     = 8;

endpackage

// File: rtl/mem_watchdog.sv
// Busy-cycle counter that flags a hung memory transaction.
// timeout_o is high during the LIMIT-th enabled cycle after a clear.
module mem_watchdog
    import unified_mem_arbiter_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam logic [WDOG_W-1:0] LAST_CNT = WDOG_W'(LIMIT - 1);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {WDOG_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = en_i && !clr_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, variable-latency memory between instruction fetch and data access.
// Data wins arbitration unless fetch has waited through MAX_DM_CONSEC data grants.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int AW             = DEFAULT_AW,
    parameter int DW             = DEFAULT_DW,
    parameter int MAX_DM_CONSEC  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [DW-1:0] if_data_o,
    output logic          if_valid_o,
    output logic          stall_if_o,
    input  logic          dm_read_i,
    input  logic          dm_write_i,
    input  logic [AW-1:0] dm_addr_i,
    input  logic [DW-1:0] dm_wdata_i,
    output logic [DW-1:0] dm_rdata_o,
    output logic          dm_valid_o,
    output logic          stall_mem_o,
    output logic          MEM_req_o,
    output logic          MEM_we_o,
    output logic [AW-1:0] MEM_addr_o,
    output logic [DW-1:0] MEM_wdata_o,
    input  logic [DW-1:0] MEM_rdata_i,
    input  logic          MEM_ack_i,
    output logic          err_o
);

    localparam logic [7:0] MAX_CONSEC = 8'(MAX_DM_CONSEC);

    arb_state_e    state_q, state_d;
    logic [7:0]    consec_q, consec_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_data_q, if_data_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_valid_q, if_valid_d;
    logic          dm_valid_q, dm_valid_d;
    logic          err_q, err_d;

    logic dm_pend;
    logic busy;
    logic timeout;

    assign dm_pend = dm_read_i | dm_write_i;
    assign busy    = (state_q != IDLE);

    mem_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_i     (!busy),
        .en_i      (busy),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d    = state_q;
        consec_d   = consec_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_data_d  = if_data_q;
        dm_rdata_d = dm_rdata_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                // Only grants made while fetch is waiting count towards starvation.
                if (!if_req_i) begin
                    consec_d = '0;
                end
                if (dm_pend && (!if_req_i || (consec_q < MAX_CONSEC))) begin
                    state_d = DM_BUSY;
                    if (if_req_i) begin
                        consec_d = consec_q + 1'b1;
                    end
                    req_d   = 1'b1;
                    we_d    = dm_write_i;
                    addr_d  = dm_addr_i;
                    wdata_d = dm_wdata_i;
                end else if (if_req_i) begin
                    state_d  = IF_BUSY;
                    consec_d = '0;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = if_addr_i;
                end
            end
            IF_BUSY: begin
                if (MEM_ack_i) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    if_data_d  = MEM_rdata_i;
                    if_valid_d = 1'b1;
                end else if (timeout) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    err_d      = 1'b1;
                    if_data_d  = '0;
                    if_valid_d = 1'b1;
                end
            end
            DM_BUSY: begin
                // Stores complete without touching the load-data register.
                if (MEM_ack_i) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    dm_valid_d = 1'b1;
                    if (!we_q) begin
                        dm_rdata_d = MEM_rdata_i;
                    end
                end else if (timeout) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    err_d      = 1'b1;
                    dm_rdata_d = '0;
                    dm_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            consec_q   <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_data_q  <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            consec_q   <= consec_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_data_q  <= if_data_d;
            dm_rdata_q <= dm_rdata_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
            err_q      <= err_d;
        end
    end

    assign MEM_req_o   = req_q;
    assign MEM_we_o    = we_q;
    assign MEM_addr_o  = addr_q;
    assign MEM_wdata_o = wdata_q;
    assign if_data_o   = if_data_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign if_valid_o  = if_valid_q;
    assign dm_valid_o  = dm_valid_q;
    assign err_o       = err_q;

    assign stall_if_o  = if_req_i & !if_valid_q;
    assign stall_mem_o = dm_pend & !dm_valid_q;

endmodule
